// File: rtl/dma_pingpong_buffer_if.sv
// Handshake bundle between the DMA writer / compute reader and the ping-pong dump buffer.
interface dma_pingpong_buffer_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              bank_valid;
    logic              rd_done;
    logic              fill_pulse;
    logic              err_drop;
    logic              err_addr;
    logic              err_clr;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_done, err_clr,
        input  wr_ready, rd_data, rd_valid, bank_valid, fill_pulse, err_drop, err_addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_done, err_clr,
        output wr_ready, rd_data, rd_valid, bank_valid, fill_pulse, err_drop, err_addr
    );
endinterface

// File: rtl/dma_pingpong_buffer.sv
// Double-banked DMA dump memory: DMA fills one bank by address while the consumer
// reads the other completed bank; banks are released explicitly by the consumer.
module dma_pingpong_buffer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 5,
    parameter int unsigned PAD    = 1,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_pingpong_buffer_if.slave  bus
);
    localparam int unsigned FILL  = DEPTH - PAD;
    localparam int unsigned IDX_W = (FILL > 1) ? $clog2(FILL) : 1;

    // Padding entries are never stored; only the FILL writable words exist.
    logic [DATA_W-1:0]     r_mem [2][FILL];
    logic [1:0][FILL-1:0]  r_vbits;
    logic [1:0]            r_full;
    logic                  r_wb;
    logic                  r_rb;
    logic                  r_wr_ready;
    logic                  r_bank_valid;
    logic                  r_rd_valid;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_fill_pulse;
    logic                  r_err_drop;
    logic                  r_err_addr;

    logic                  w_wr_addr_ok;
    logic                  w_rd_addr_ok;
    logic                  w_wr_acc;
    logic                  w_read;
    logic                  w_release;
    logic                  w_fill;
    logic [1:0][FILL-1:0]  w_vbits_n;
    logic [1:0]            w_full_n;
    logic                  w_wb_n;
    logic                  w_rb_n;

    assign w_wr_addr_ok = bus.wr_addr < ADDR_W'(FILL);
    assign w_rd_addr_ok = bus.rd_addr < ADDR_W'(FILL);
    assign w_wr_acc     = bus.wr_en & ~r_full[r_wb] & w_wr_addr_ok;
    assign w_read       = bus.rd_en & r_full[r_rb];
    assign w_release    = bus.rd_done & r_full[r_rb];

    // Next bank bookkeeping; a write and a release never target the same bank.
    always_comb begin
        w_vbits_n = r_vbits;
        w_full_n  = r_full;
        w_fill    = 1'b0;
        w_rb_n    = r_rb;
        if (w_wr_acc) begin
            w_vbits_n[r_wb][IDX_W'(bus.wr_addr)] = 1'b1;
            if (&w_vbits_n[r_wb]) begin
                w_full_n[r_wb] = 1'b1;
                w_fill         = 1'b1;
            end
        end
        if (w_release) begin
            w_full_n[r_rb]  = 1'b0;
            w_vbits_n[r_rb] = '0;
            w_rb_n          = ~r_rb;
        end
        // Zero-bubble hand-over to the other bank as soon as it is free.
        w_wb_n = (w_full_n[r_wb] && !w_full_n[~r_wb]) ? ~r_wb : r_wb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vbits      <= '0;
            r_full       <= '0;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_wr_ready   <= 1'b1;
            r_bank_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_fill_pulse <= 1'b0;
            r_err_drop   <= 1'b0;
            r_err_addr   <= 1'b0;
        end else begin
            r_vbits      <= w_vbits_n;
            r_full       <= w_full_n;
            r_wb         <= w_wb_n;
            r_rb         <= w_rb_n;
            r_wr_ready   <= ~w_full_n[w_wb_n];
            r_bank_valid <= w_full_n[w_rb_n];
            r_fill_pulse <= w_fill;
            r_rd_valid   <= w_read;
            if (w_read) begin
                r_rd_data <= w_rd_addr_ok ? r_mem[r_rb][IDX_W'(bus.rd_addr)] : '0;
            end
            if (bus.err_clr) begin
                r_err_drop <= 1'b0;
                r_err_addr <= 1'b0;
            end else begin
                r_err_drop <= r_err_drop | (bus.wr_en & r_full[r_wb]);
                r_err_addr <= r_err_addr | (bus.wr_en & ~w_wr_addr_ok);
            end
        end
    end

    // Storage is deliberately not reset; validity lives in r_vbits/r_full.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wb][IDX_W'(bus.wr_addr)] <= bus.wr_data;
        end
    end

    assign bus.wr_ready   = r_wr_ready;
    assign bus.bank_valid = r_bank_valid;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.fill_pulse = r_fill_pulse;
    assign bus.err_drop   = r_err_drop;
    assign bus.err_addr   = r_err_addr;
endmodule

// File: tb/tb_dma_pingpong_buffer.sv
// Scoreboard bench for dma_pingpong_buffer: directed test-plan sequences, then random traffic
// checked against a queue-of-full-banks reference model.
module tb_dma_pingpong_buffer;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 5;
    localparam int unsigned PAD    = 1;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned FILL   = DEPTH - PAD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dma_pingpong_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PAD(PAD), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bank being filled, FIFO of completed banks (oldest first).
    logic [DATA_W-1:0] m_mem [2][FILL];
    bit                m_wr  [2][FILL];
    int                m_fullq[$];
    int                m_fb;
    bit                m_edrop, m_eaddr, m_fill;
    logic [DATA_W-1:0] m_last;
    logic [DATA_W-1:0] exp_q[$];

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < int'(FILL); a++) m_wr[b][a] = 1'b0;
        m_fullq.delete();
        exp_q.delete();
        m_fb = 0; m_edrop = 0; m_eaddr = 0; m_fill = 0; m_last = '0;
    endtask

    task automatic model_step();
        bit wrdy, bv, all;
        int wa, ra, rbank;
        logic [DATA_W-1:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wrdy   = m_fullq.size() < 2;
        bv     = m_fullq.size() > 0;
        wa     = int'(bus.wr_addr);
        ra     = int'(bus.rd_addr);
        m_fill = 1'b0;
        if (bus.rd_en && bv) begin
            rbank = m_fullq[0];
            v = (ra < int'(FILL)) ? m_mem[rbank][ra] : '0;
            exp_q.push_back(v);
            m_last = v;
        end
        if (bus.err_clr) begin
            m_edrop = 0;
            m_eaddr = 0;
        end else begin
            if (bus.wr_en && !wrdy) m_edrop = 1;
            if (bus.wr_en && wa >= int'(FILL)) m_eaddr = 1;
        end
        if (bus.wr_en && wrdy && wa < int'(FILL)) begin
            m_mem[m_fb][wa] = bus.wr_data;
            m_wr[m_fb][wa]  = 1'b1;
            all = 1'b1;
            for (int a = 0; a < int'(FILL); a++) if (!m_wr[m_fb][a]) all = 1'b0;
            m_fill = all;
        end
        if (bus.rd_done && bv) begin
            rbank = m_fullq.pop_front();
            for (int a = 0; a < int'(FILL); a++) m_wr[rbank][a] = 1'b0;
        end
        if (m_fill) begin
            m_fullq.push_back(m_fb);
            m_fb = 1 - m_fb;
        end
    endtask

    task automatic cycle(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                         input bit re, input int ra, input bit done, input bit clr);
        bus.wr_en   = we;
        bus.wr_addr = ADDR_W'(wa);
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ADDR_W'(ra);
        bus.rd_done = done;
        bus.err_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        chk("wr_ready",   DATA_W'(bus.wr_ready),   DATA_W'(m_fullq.size() < 2));
        chk("bank_valid", DATA_W'(bus.bank_valid), DATA_W'(m_fullq.size() > 0));
        chk("fill_pulse", DATA_W'(bus.fill_pulse), DATA_W'(m_fill));
        chk("err_drop",   DATA_W'(bus.err_drop),   DATA_W'(m_edrop));
        chk("err_addr",   DATA_W'(bus.err_addr),   DATA_W'(m_eaddr));
        chk("rd_data",    bus.rd_data,             m_last);
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        cycle(1, a, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        cycle(0, 0, '0, 1, a, 0, 0);
    endtask

    // Monitor: every rd_valid must match the oldest pending expected read word.
    always @(negedge clk) begin
        logic exp_v;
        logic [DATA_W-1:0] e;
        exp_v = exp_q.size() != 0;
        chk("rd_valid", DATA_W'(bus.rd_valid), DATA_W'(exp_v));
        if (exp_v) begin
            e = exp_q.pop_front();
            if (bus.rd_valid) chk("rd_word", bus.rd_data, e);
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        idle(); idle();
        rst_n = 1'b1;
        idle();

        // Fill bank 0 and read it back including the padded and out-of-range slots.
        for (int a = 0; a < 4; a++) wr(a, DATA_W'(64'hA0 + a));
        idle();
        for (int a = 0; a < 6; a++) rd(a);
        idle();

        // Fill bank 1, overflow, release, refill bank 0.
        for (int a = 0; a < 4; a++) wr(a, DATA_W'(64'hB0 + a));
        wr(1, DATA_W'(64'hDEAD));
        cycle(0, 0, '0, 1, 1, 1, 0);
        for (int a = 0; a < 4; a++) rd(a);
        for (int a = 3; a >= 0; a--) wr(a, DATA_W'(64'hC0 + a));
        cycle(0, 0, '0, 0, 0, 1, 1);
        for (int a = 0; a < 5; a++) rd(a);

        // Address error and overwrite of a valid entry.
        cycle(0, 0, '0, 0, 0, 1, 1);
        wr(4, DATA_W'(64'hEE));
        wr(2, DATA_W'(64'h11));
        wr(2, DATA_W'(64'h22));
        wr(0, DATA_W'(64'h30));
        wr(1, DATA_W'(64'h31));
        idle();
        wr(3, DATA_W'(64'h33));
        rd(2);

        // Last write to the filling bank coincides with releasing the read bank.
        for (int a = 0; a < 3; a++) wr(a, DATA_W'(64'h40 + a));
        cycle(1, 3, DATA_W'(64'h43), 1, 2, 1, 0);
        wr(0, DATA_W'(64'h50));
        rd(3);

        // Reset mid-fill, then reads/releases with nothing valid.
        cycle(0, 0, '0, 0, 0, 1, 1);
        for (int a = 0; a < 3; a++) wr(a, DATA_W'(64'h60 + a));
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        cycle(0, 0, '0, 1, 0, 1, 0);
        for (int a = 0; a < 3; a++) wr(a, DATA_W'(64'h70 + a));
        cycle(0, 0, '0, 1, 1, 1, 0);
        wr(3, DATA_W'(64'h73));
        rd(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)),
                  {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        rst_n = 1'b1;
        idle(); idle();
        chk("rd_queue_drained", DATA_W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_pingpong_buffer.md
# dma_pingpong_buffer

Double-banked DMA dump memory sitting between the AXI-DMA stream unpacker and the VAE forward-path consumers. The DMA side writes addressed words into one bank while the compute side reads the other, completed bank, so input dumps overlap with computation. It generalises the single-bank dump buffer in four ways: parametrised width, depth and padding; per-entry valid tracking instead of a raw write counter; explicit bank release; and sticky error flags.

## Interface
- DATA_W, 64, word width
- DEPTH, 5, entries per bank (fillable + padding)
- PAD, 1, top entries per bank that are hard-wired zero and not writable; FILL = DEPTH-PAD, 1 ≤ FILL ≤ DEPTH
- ADDR_W, 3, address width, 2^ADDR_W ≥ DEPTH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  entry index within current write bank
- wr_data  in  DATA_W  write word
- wr_ready  out  1  current write bank not full; = !full[wb]
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  entry index within read bank
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  one-cycle pulse qualifying rd_data
- bank_valid  out  1  read bank is full; = full[rb]
- rd_done  in  1  consumer releases read bank
- fill_pulse  out  1  one-cycle pulse, a bank became full
- err_drop  out  1  sticky: write attempted while wr_ready=0
- err_addr  out  1  sticky: write to wr_addr ≥ FILL
- err_clr  in  1  clears both sticky flags

## Operation
- State: mem[2][DEPTH], vbits[2] (FILL bits), full[2], write pointer wb, read pointer rb.
- Accepted write: wr_en & wr_ready & wr_addr < FILL. Stores mem[wb][wr_addr] and sets vbits[wb][wr_addr]. Rewriting an already-valid entry overwrites the data and does not change the count.
- Write with wr_addr ≥ FILL: dropped, err_addr set. Write with wr_ready=0: dropped, err_drop set. If both apply, both flags set.
- Bank full: at the edge where vbits[wb] becomes all-ones, full[wb] goes to 1 and fill_pulse is asserted for that cycle.
- wb rule, zero bubble: at any edge where post-edge full[wb]=1 and post-edge full[~wb]=0, wb toggles.
- Both banks full: wr_ready=0 until rd_done frees rb. wb then moves to the freed bank on that same edge.
- Read: rd_en & bank_valid. The next cycle, rd_data = mem[rb][rd_addr] and rd_valid=1.
  - Reads at rd_addr in [FILL, DEPTH) return 0.
  - Reads at rd_addr ≥ DEPTH return 0.
- rd_en with bank_valid=0: rd_valid=0, rd_data holds.
- Release: rd_done & bank_valid clears full[rb] and vbits[rb], then toggles rb. rd_done with bank_valid=0 is ignored.
- Fill order and read order both alternate 0,1,0,…, so rb always names the oldest full bank.
- err_clr has priority over a same-cycle set.

## Timing
- Reset values:
  - wr_ready=1, bank_valid=0, rd_valid=0, rd_data=0, fill_pulse=0, err_drop=0, err_addr=0
  - wb=rb=0, full=0, vbits=0
  - mem contents are not reset.
- Reset mid-fill or mid-read discards all banks. Partially written data never becomes readable.
- Write-to-bank_valid latency: the last filling write at edge E gives bank_valid=1 and fill_pulse=1 in the cycle after E.
- Read latency is 1 cycle. Back-to-back rd_en gives one word per cycle.
- rd_en and rd_done in the same cycle:
  - the read uses the old rb, and rd_valid/rd_data still appear the next cycle;
  - the release takes effect at that edge.
- Last filling write to wb and rd_done freeing ~wb in the same cycle: both apply, and wb toggles at that edge with wr_ready staying 1.
- Write and read to the same bank in the same cycle cannot occur, because the read bank is full and therefore never writable.

## Test plan
- Fill bank 0 with addresses 0..3 (data 0xA0..0xA3, DEPTH=5, PAD=1) -> fill_pulse 1 cycle after the 4th write, bank_valid=1, wr_ready stays 1, wb=1.
  - Then read addr 0..4 -> 0xA0..0xA3, 0 at a 1-cycle latency.
- Fill both banks without rd_done -> wr_ready=0 after the 8th write.
  - A 9th write sets err_drop and leaves memory unchanged.
  - rd_done -> wr_ready=1 on the next cycle, and the new writes land in bank 0.
- Write addr 4 -> err_addr=1 and no vbits change. Write addr 2 twice (0x11 then 0x22) -> bank still needs 3 more entries, and reading addr 2 gives 0x22.
- Last write to bank 1 in the same cycle as rd_done on bank 0 -> wr_ready stays 1, the next write goes to bank 0, and bank_valid stays 1 (now bank 1).
- Assert rst_n=0 after 3 of 4 writes -> all outputs at reset values, and bank_valid stays 0 until 4 fresh writes.
- rd_en with bank_valid=0, and rd_done with bank_valid=0 -> rd_valid=0, rd_data unchanged, and no state change.
